// File: rtl/jtkunio_pkg.sv
// Shared constants for the Kunio main-CPU / protection-MCU interface.
// Bit positions of the status pair returned to the main CPU, plus the main I/O offset.
package jtkunio_pkg;

    localparam int MCU_ST_M2M  = 0;
    localparam int MCU_ST_MC2M = 1;

    localparam logic [2:0] MAIN2MCU = 3'd4;

    function automatic logic [1:0] mcu_st_pack(input logic mc2m_full, input logic m2m_full);
        logic [1:0] st;
        st              = 2'b00;
        st[MCU_ST_MC2M] = mc2m_full;
        st[MCU_ST_M2M]  = m2m_full;
        return st;
    endfunction

endpackage

// File: rtl/jtkunio_mbox_dir.sv
// One mailbox direction: rising-edge detection on writer/reader strobes,
// the data latch, its full flag and a sticky overrun bit.
module jtkunio_mbox_dir #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_i,
    input  logic              rd_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              ovr_o,
    output logic              wr_evt_o,
    output logic              rd_evt_o
);

    logic              wr_prev_q, rd_prev_q;
    logic [DATA_W-1:0] data_q, data_d;
    logic              full_q, full_d;
    logic              ovr_q, ovr_d;
    logic              wr_evt, rd_evt;

    // Strobes are bus-cycle levels; only the low-to-high transition is an event.
    assign wr_evt = wr_i & ~wr_prev_q;
    assign rd_evt = rd_i & ~rd_prev_q;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        ovr_d  = ovr_q;
        if (rd_evt) begin
            full_d = 1'b0;
        end
        // A write landing with a read in the same cycle wins, and the old byte was consumed.
        if (wr_evt) begin
            data_d = din_i;
            full_d = 1'b1;
            if (full_q && !rd_evt) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_prev_q <= 1'b0;
            rd_prev_q <= 1'b0;
            data_q    <= '0;
            full_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            wr_prev_q <= wr_i;
            rd_prev_q <= rd_i;
            data_q    <= data_d;
            full_q    <= full_d;
            ovr_q     <= ovr_d;
        end
    end

    assign dout_o   = data_q;
    assign full_o   = full_q;
    assign ovr_o    = ovr_q;
    assign wr_evt_o = wr_evt;
    assign rd_evt_o = rd_evt;

endmodule

// File: rtl/jtkunio_mcu_latch.sv
// Bidirectional mailbox between the Kunio main 6502 and the 68705 protection MCU.
// Two independent directions plus the MCU interrupt request raised by main writes.
module jtkunio_mcu_latch
    import jtkunio_pkg::*;
#(
    parameter bit MCU_EN    = 1'b1,
    parameter bit IRQ_ON_WR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       main_wr,
    input  logic       main_rd,
    input  logic [7:0] main_dout,
    output logic [7:0] main_din,
    output logic [1:0] mcu_st,
    input  logic       mcu_wr,
    input  logic       mcu_rd,
    input  logic [7:0] mcu_dout,
    output logic [7:0] mcu_din,
    output logic       mcu_irq,
    output logic [1:0] ovr
);

    generate
        if (MCU_EN) begin : g_mbox
            logic m2m_full, mc2m_full;
            logic m2m_ovr, mc2m_ovr;
            logic m2m_wr_evt, m2m_rd_evt;
            logic unused_mc2m_evt;
            logic irq_q, irq_d;

            jtkunio_mbox_dir #(.DATA_W(8)) u_main2mcu (
                .clk      (clk),
                .rst      (rst),
                .wr_i     (main_wr),
                .rd_i     (mcu_rd),
                .din_i    (main_dout),
                .dout_o   (mcu_din),
                .full_o   (m2m_full),
                .ovr_o    (m2m_ovr),
                .wr_evt_o (m2m_wr_evt),
                .rd_evt_o (m2m_rd_evt)
            );

            logic mc2m_wr_evt, mc2m_rd_evt;

            jtkunio_mbox_dir #(.DATA_W(8)) u_mcu2main (
                .clk      (clk),
                .rst      (rst),
                .wr_i     (mcu_wr),
                .rd_i     (main_rd),
                .din_i    (mcu_dout),
                .dout_o   (main_din),
                .full_o   (mc2m_full),
                .ovr_o    (mc2m_ovr),
                .wr_evt_o (mc2m_wr_evt),
                .rd_evt_o (mc2m_rd_evt)
            );

            assign unused_mc2m_evt = mc2m_wr_evt ^ mc2m_rd_evt;

            // Write wins over a same-cycle MCU read, matching the full flag.
            always_comb begin
                irq_d = irq_q;
                if (m2m_rd_evt) begin
                    irq_d = 1'b0;
                end
                if (m2m_wr_evt) begin
                    irq_d = IRQ_ON_WR;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    irq_q <= 1'b0;
                end else begin
                    irq_q <= irq_d;
                end
            end

            assign mcu_irq = irq_q;
            assign mcu_st  = mcu_st_pack(mc2m_full, m2m_full);
            assign ovr     = {mc2m_ovr, m2m_ovr};
        end else begin : g_stub
            logic unused_inputs;

            assign unused_inputs = ^{clk, rst, main_wr, main_rd, main_dout,
                                     mcu_wr, mcu_rd, mcu_dout};
            assign main_din = 8'h00;
            assign mcu_din  = 8'h00;
            assign mcu_st   = 2'b00;
            assign mcu_irq  = 1'b0;
            assign ovr      = 2'b00;
        end
    endgenerate

endmodule

// File: tb/tb_jtkunio_mcu_latch.sv
// Directed bench for the Kunio MCU mailbox: an active instance and an MCU_EN=0 stub.
module tb_jtkunio_mcu_latch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       main_wr = 1'b0, main_rd = 1'b0, mcu_wr = 1'b0, mcu_rd = 1'b0;
    logic [7:0] main_dout = 8'h00, mcu_dout = 8'h00;
    logic [7:0] main_din, mcu_din;
    logic [1:0] mcu_st, ovr;
    logic       mcu_irq;

    logic       o_main_wr = 1'b0, o_main_rd = 1'b0, o_mcu_wr = 1'b0, o_mcu_rd = 1'b0;
    logic [7:0] o_main_dout = 8'h00, o_mcu_dout = 8'h00;
    logic [7:0] o_main_din, o_mcu_din;
    logic [1:0] o_mcu_st, o_ovr;
    logic       o_mcu_irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jtkunio_mcu_latch dut (
        .clk(clk), .rst(rst),
        .main_wr(main_wr), .main_rd(main_rd), .main_dout(main_dout), .main_din(main_din),
        .mcu_st(mcu_st),
        .mcu_wr(mcu_wr), .mcu_rd(mcu_rd), .mcu_dout(mcu_dout), .mcu_din(mcu_din),
        .mcu_irq(mcu_irq), .ovr(ovr)
    );

    jtkunio_mcu_latch #(.MCU_EN(1'b0)) dut_off (
        .clk(clk), .rst(rst),
        .main_wr(o_main_wr), .main_rd(o_main_rd), .main_dout(o_main_dout), .main_din(o_main_din),
        .mcu_st(o_mcu_st),
        .mcu_wr(o_mcu_wr), .mcu_rd(o_mcu_rd), .mcu_dout(o_mcu_dout), .mcu_din(o_mcu_din),
        .mcu_irq(o_mcu_irq), .ovr(o_ovr)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with all strobes low
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("rst_main_din", main_din, 8'h00);
        chk("rst_mcu_din", mcu_din, 8'h00);
        chk("rst_mcu_st", {6'd0, mcu_st}, 8'h00);
        chk("rst_irq", {7'd0, mcu_irq}, 8'h00);
        chk("rst_ovr", {6'd0, ovr}, 8'h00);

        // Main write held 20 clk
        main_dout = 8'h5A;
        main_wr   = 1'b1;
        tick();
        chk("wr1_mcu_din", mcu_din, 8'h5A);
        chk("wr1_mcu_st", {6'd0, mcu_st}, 8'h01);
        chk("wr1_irq", {7'd0, mcu_irq}, 8'h01);
        tick(19);
        main_wr = 1'b0;
        tick();
        chk("wr1_one_event_ovr", {6'd0, ovr}, 8'h00);
        chk("wr1_hold_st", {6'd0, mcu_st}, 8'h01);

        // MCU read
        mcu_rd = 1'b1;
        tick();
        chk("rd1_mcu_st", {6'd0, mcu_st}, 8'h00);
        chk("rd1_irq", {7'd0, mcu_irq}, 8'h00);
        chk("rd1_mcu_din", mcu_din, 8'h5A);
        tick(3);
        mcu_rd = 1'b0;
        tick();

        // Two main writes without MCU read -> overrun
        main_dout = 8'h11; main_wr = 1'b1; tick(4); main_wr = 1'b0; tick(2);
        main_dout = 8'h22; main_wr = 1'b1; tick(4); main_wr = 1'b0; tick(2);
        chk("ovr_mcu_din", mcu_din, 8'h22);
        chk("ovr_ovr", {6'd0, ovr}, 8'h01);
        chk("ovr_st0", {7'd0, mcu_st[0]}, 8'h01);

        // MCU -> main reply
        mcu_dout = 8'hC3; mcu_wr = 1'b1;
        tick();
        chk("rep_main_din", main_din, 8'hC3);
        chk("rep_st1_set", {7'd0, mcu_st[1]}, 8'h01);
        tick(3);
        mcu_wr = 1'b0; tick(2);
        main_rd = 1'b1;
        tick();
        chk("rep_st1_clr", {7'd0, mcu_st[1]}, 8'h00);
        chk("rep_ovr1", {7'd0, ovr[1]}, 8'h00);
        chk("rep_main_din_kept", main_din, 8'hC3);
        tick(3);
        main_rd = 1'b0; tick();

        // Reset mid-transfer clears flags, data, sticky overrun
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_mcu_st", {6'd0, mcu_st}, 8'h00);
        chk("rst2_ovr", {6'd0, ovr}, 8'h00);
        chk("rst2_mcu_din", mcu_din, 8'h00);
        chk("rst2_main_din", main_din, 8'h00);
        chk("rst2_irq", {7'd0, mcu_irq}, 8'h00);

        // Simultaneous main write and MCU read while full
        main_dout = 8'h33; main_wr = 1'b1; tick(2); main_wr = 1'b0; tick(2);
        chk("sim_pre_st", {6'd0, mcu_st}, 8'h01);
        main_dout = 8'h44; main_wr = 1'b1; mcu_rd = 1'b1;
        tick();
        chk("sim_mcu_din", mcu_din, 8'h44);
        chk("sim_st0", {7'd0, mcu_st[0]}, 8'h01);
        chk("sim_irq", {7'd0, mcu_irq}, 8'h01);
        chk("sim_ovr0", {7'd0, ovr[0]}, 8'h00);
        tick(2);
        main_wr = 1'b0; mcu_rd = 1'b0; tick();

        // Cross-direction events in the same clk
        mcu_rd = 1'b1; tick(); mcu_rd = 1'b0; tick();
        main_dout = 8'h77; mcu_dout = 8'h88; main_wr = 1'b1; mcu_wr = 1'b1;
        tick();
        chk("both_mcu_st", {6'd0, mcu_st}, 8'h03);
        chk("both_mcu_din", mcu_din, 8'h77);
        chk("both_main_din", main_din, 8'h88);
        chk("both_ovr", {6'd0, ovr}, 8'h00);
        main_wr = 1'b0; mcu_wr = 1'b0; tick();

        // Stub instance under random strobes
        for (int i = 0; i < 1000; i++) begin
            o_main_wr   = 1'($urandom);
            o_main_rd   = 1'($urandom);
            o_mcu_wr    = 1'($urandom);
            o_mcu_rd    = 1'($urandom);
            o_main_dout = 8'($urandom);
            o_mcu_dout  = 8'($urandom);
            tick();
            chk("off_outputs", {o_mcu_st, o_mcu_irq, o_ovr, 3'd0}, 8'h00);
            chk("off_main_din", o_main_din, 8'h00);
            if (o_mcu_din !== 8'h00) chk("off_mcu_din", o_mcu_din, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
